// File: rtl/gate_lamp_event_multi.sv
// Toggle lamps evaluated by a run-time selectable gate; each change of the gate
// result is queued in a saturating counter and replayed as spaced output pulses.
module gate_lamp_event_multi #(
  parameter int INPUT_COUNT   = 2,
  parameter int OUTPUT_COUNT  = 2,
  parameter int PENDING_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     logic_reset,
  input  logic [2:0]               mode,
  input  logic [INPUT_COUNT-1:0]   trig,
  output logic [OUTPUT_COUNT-1:0]  out,
  output logic [INPUT_COUNT-1:0]   lamps,
  output logic                     result,
  output logic [PENDING_WIDTH-1:0] pending,
  output logic                     overflow
);

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP} state_t;

  localparam logic [PENDING_WIDTH-1:0] PEND_MAX = {PENDING_WIDTH{1'b1}};

  state_t                   state_q, state_d;
  logic [INPUT_COUNT-1:0]   lamps_q, lamps_d;
  logic [PENDING_WIDTH-1:0] pending_q, pending_d;
  logic [OUTPUT_COUNT-1:0]  out_q, out_d;
  logic                     result_q, result_d;
  logic                     primed_q, primed_d;
  logic                     overflow_q, overflow_d;
  logic                     f, inc, dec;

  always_comb begin
    f = 1'b0;
    case (mode)
      3'd0:    f = &lamps_q;
      3'd1:    f = |lamps_q;
      3'd2:    f = ^lamps_q;
      3'd3:    f = ~(&lamps_q);
      3'd4:    f = ~(|lamps_q);
      3'd5:    f = ~(^lamps_q);
      default: f = 1'b0;
    endcase
  end

  // The priming edge only loads the result, so inverting gates on all-zero
  // lamps do not fire an event straight out of reset.
  assign inc = primed_q && (f != result_q);
  assign dec = (state_q == S_IDLE) && ((pending_q != '0) || inc);

  always_comb begin
    lamps_d    = lamps_q ^ trig;
    result_d   = f;
    primed_d   = 1'b1;
    pending_d  = pending_q;
    overflow_d = overflow_q;
    if (inc && !dec) begin
      if (pending_q == PEND_MAX) overflow_d = 1'b1;
      else                       pending_d  = pending_q + PENDING_WIDTH'(1);
    end else if (dec && !inc) begin
      pending_d = pending_q - PENDING_WIDTH'(1);
    end

    state_d = state_q;
    case (state_q)
      S_IDLE:  if (dec) state_d = S_PULSE;
      S_PULSE: state_d = S_GAP;
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    out_d = {OUTPUT_COUNT{state_d == S_PULSE}};
  end

  always_ff @(posedge clk or posedge logic_reset) begin
    if (logic_reset) begin
      state_q    <= S_IDLE;
      lamps_q    <= '0;
      pending_q  <= '0;
      out_q      <= '0;
      result_q   <= 1'b0;
      primed_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lamps_q    <= lamps_d;
      pending_q  <= pending_d;
      out_q      <= out_d;
      result_q   <= result_d;
      primed_q   <= primed_d;
      overflow_q <= overflow_d;
    end
  end

  assign out      = out_q;
  assign lamps    = lamps_q;
  assign result   = result_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_gate_lamp_event_multi.sv
// Directed bench: default instance plus a 2-bit pending instance sharing stimulus.
module tb_gate_lamp_event_multi;
  logic       clk = 1'b0;
  logic       logic_reset = 1'b1;
  logic [2:0] mode = 3'd0;
  logic [1:0] trig = 2'b00;

  logic [1:0] out_a, lamps_a, out_b, lamps_b;
  logic       result_a, overflow_a, result_b, overflow_b;
  logic [3:0] pending_a;
  logic [1:0] pending_b;

  int checks = 0, errors = 0;
  int cyc = 0;
  int pulses_a, pulses_b, last_a, last_b, minsp_a, maxsp_a, minsp_b, maxsp_b;
  int peak_a, peak_b;

  always #5 clk = ~clk;

  gate_lamp_event_multi #(.INPUT_COUNT(2), .OUTPUT_COUNT(2), .PENDING_WIDTH(4)) dut (
    .clk(clk), .logic_reset(logic_reset), .mode(mode), .trig(trig),
    .out(out_a), .lamps(lamps_a), .result(result_a), .pending(pending_a), .overflow(overflow_a));

  gate_lamp_event_multi #(.INPUT_COUNT(2), .OUTPUT_COUNT(2), .PENDING_WIDTH(2)) dut_p2 (
    .clk(clk), .logic_reset(logic_reset), .mode(mode), .trig(trig),
    .out(out_b), .lamps(lamps_b), .result(result_b), .pending(pending_b), .overflow(overflow_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    pulses_a = 0; pulses_b = 0; last_a = -1; last_b = -1;
    minsp_a = 1000; maxsp_a = 0; minsp_b = 1000; maxsp_b = 0;
    peak_a = 0; peak_b = 0;
  endtask

  // Advance one edge, sample 1ns later and accumulate pulse statistics.
  task automatic step();
    @(posedge clk); #1;
    cyc++;
    if (out_a != 2'b00) begin
      pulses_a++;
      if (last_a >= 0) begin
        if (cyc - last_a < minsp_a) minsp_a = cyc - last_a;
        if (cyc - last_a > maxsp_a) maxsp_a = cyc - last_a;
      end
      last_a = cyc;
    end
    if (out_b != 2'b00) begin
      pulses_b++;
      if (last_b >= 0) begin
        if (cyc - last_b < minsp_b) minsp_b = cyc - last_b;
        if (cyc - last_b > maxsp_b) maxsp_b = cyc - last_b;
      end
      last_b = cyc;
    end
    if (int'(pending_a) > peak_a) peak_a = int'(pending_a);
    if (int'(pending_b) > peak_b) peak_b = int'(pending_b);
  endtask

  task automatic do_reset(input logic [2:0] m);
    logic_reset = 1'b1; trig = 2'b00; mode = m;
    #2;
    @(negedge clk);
    logic_reset = 1'b0;
    clear_stats();
  endtask

  initial begin
    clear_stats();
    #3;
    chk("rst_out", 32'(out_a), 32'h0);
    chk("rst_lamps", 32'(lamps_a), 32'h0);
    chk("rst_pending", 32'(pending_a), 32'h0);
    chk("rst_result", 32'(result_a), 32'h0);
    chk("rst_overflow", 32'(overflow_a), 32'h0);

    // 1: XOR, single toggle -> one pulse two cycles after trig
    do_reset(3'd2);
    step(); step();
    trig = 2'b01; step();
    chk("t1_lamps", 32'(lamps_a), 32'h1);
    chk("t1_out_early", 32'(out_a), 32'h0);
    trig = 2'b00; step();
    chk("t1_out_pulse", 32'(out_a), 32'h3);
    chk("t1_result", 32'(result_a), 32'h1);
    chk("t1_pending", 32'(pending_a), 32'h0);
    step();
    chk("t1_out_gap", 32'(out_a), 32'h0);
    repeat (6) step();
    chk("t1_pulses", 32'(pulses_a), 32'd1);

    // 2: NAND on all-zero lamps primes to 1 without an event
    do_reset(3'd3);
    step();
    chk("t2_result_primed", 32'(result_a), 32'h1);
    repeat (9) step();
    chk("t2_pulses", 32'(pulses_a), 32'd0);
    chk("t2_pending", 32'(pending_a), 32'h0);

    // 3: OR, two lamps toggled back to back -> one result change
    do_reset(3'd1);
    step(); step();
    trig = 2'b01; step();
    chk("t3_lamps01", 32'(lamps_a), 32'h1);
    trig = 2'b10; step();
    chk("t3_lamps11", 32'(lamps_a), 32'h3);
    trig = 2'b00;
    repeat (8) step();
    chk("t3_pulses", 32'(pulses_a), 32'd1);

    // 4 and 5: XOR with trig held; default instance drains 6, 2-bit saturates
    do_reset(3'd2);
    step(); step();
    trig = 2'b01; repeat (6) step();
    trig = 2'b00; repeat (16) step();
    chk("t4_pulses", 32'(pulses_a), 32'd6);
    chk("t4_min_spacing", 32'(minsp_a), 32'd3);
    chk("t4_max_spacing", 32'(maxsp_a), 32'd3);
    chk("t4_peak", 32'(peak_a), 32'd4);
    chk("t4_pending_end", 32'(pending_a), 32'h0);
    chk("t4_overflow", 32'(overflow_a), 32'h0);

    do_reset(3'd2);
    step(); step();
    trig = 2'b01; repeat (8) step();
    trig = 2'b00; repeat (16) step();
    chk("t5_pulses", 32'(pulses_b), 32'd6);
    chk("t5_peak", 32'(peak_b), 32'd3);
    chk("t5_min_spacing", 32'(minsp_b), 32'd3);
    chk("t5_max_spacing", 32'(maxsp_b), 32'd3);
    chk("t5_overflow", 32'(overflow_b), 32'h1);
    chk("t5_pending_end", 32'(pending_b), 32'h0);
    chk("t5_wide_pulses", 32'(pulses_a), 32'd8);
    chk("t5_wide_overflow", 32'(overflow_a), 32'h0);

    // 6: reset asserted mid-pulse with two events queued
    do_reset(3'd2);
    step(); step();
    trig = 2'b01; repeat (5) step();
    chk("t6_out_pulse", 32'(out_a), 32'h3);
    chk("t6_pending2", 32'(pending_a), 32'h2);
    logic_reset = 1'b1; trig = 2'b00;
    #1;
    chk("t6_rst_out", 32'(out_a), 32'h0);
    chk("t6_rst_pending", 32'(pending_a), 32'h0);
    chk("t6_rst_lamps", 32'(lamps_a), 32'h0);
    @(negedge clk);
    logic_reset = 1'b0;
    clear_stats();
    repeat (10) step();
    chk("t6_no_pulses", 32'(pulses_a), 32'd0);
    chk("t6_lamps", 32'(lamps_a), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
